// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, the CPU data address
// and the baud divisor helper used by both the transmitter and receivers.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam logic [11:0] UART_ADDR = 12'h01e;

  // Rounded clock cycles per serial bit.
  function automatic int baud_div(input int clock_hz, input int baud_rate);
    return (clock_hz + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty derived from an occupancy count.
// A push while full is ignored; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
      $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == (AW + 1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes are queued in a small FIFO
// and shifted out LSB first on a registered tx line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 100_000,
  parameter int BAUD       = 10_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       tx
);

  localparam int DIV   = baud_div(CLOCK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx: baud divisor must be at least 2");
    end
  endgenerate

  uart_tx_state_t               state;
  logic [CNT_W-1:0]             cnt;
  logic [2:0]                   idx;
  logic [7:0]                   sh;
  logic [7:0]                   fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         bit_done;
  logic                         pop;

  assign bit_done = (cnt == BIT_END);
  // Head is taken from IDLE or at the very end of a stop bit, giving back-to-back frames.
  assign pop  = !empty && ((state == IDLE) || (state == STOP && bit_done));
  assign busy = (fifo_count != '0) || (state != IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en && full) begin
        ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (pop) begin
            sh    <= fifo_dout;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            tx    <= sh[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            sh  <= {1'b0, sh[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              tx  <= sh[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (pop) begin
              sh    <= fifo_dout;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10: idle, single frame, back-to-back
// frames, FIFO overflow, mid-frame reset and the stop/push boundary.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;
  logic       tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLOCK_HZ   (100_000),
    .BAUD       (10_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .ovf     (ovf),
    .tx      (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Starts at the falling edge of frame cycle 'skip' (cycle 0 = first start-bit cycle).
  task automatic expect_frame(input logic [7:0] b, input int skip, input string tag,
                              input bit push_end, input logic [7:0] nxt);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = skip; k < 100; k++) begin
      check({tag, " tx"}, 32'(tx), 32'(bits[k / 10]));
      check({tag, " busy"}, 32'(busy), 32'd1);
      if (push_end && k == 99) begin
        wr_en   = 1'b1;
        wr_data = nxt;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and 50 idle cycles
    for (int i = 0; i < 50; i++) begin
      check("idle tx", 32'(tx), 32'd1);
      check("idle busy", 32'(busy), 32'd0);
      check("idle empty", 32'(empty), 32'd1);
      check("idle ovf", 32'(ovf), 32'd0);
      @(negedge clk);
    end
    check("idle full", 32'(full), 32'd0);

    // Single frame 0x41
    write_byte(8'h41);
    check("w41 tx before start", 32'(tx), 32'd1);
    check("w41 empty", 32'(empty), 32'd0);
    check("w41 busy", 32'(busy), 32'd1);
    @(negedge clk);
    expect_frame(8'h41, 0, "f41", 1'b0, 8'h00);
    check("f41 busy end", 32'(busy), 32'd0);
    check("f41 tx end", 32'(tx), 32'd1);
    check("f41 empty end", 32'(empty), 32'd1);
    repeat (5) @(negedge clk);

    // Three back-to-back frames
    wr_en = 1'b1; wr_data = 8'h48;
    @(negedge clk);
    wr_data = 8'h69;
    @(negedge clk);
    check("b2b start tx", 32'(tx), 32'd0);
    wr_data = 8'h0A;
    @(negedge clk);
    wr_en = 1'b0;
    expect_frame(8'h48, 1, "f48", 1'b0, 8'h00);
    expect_frame(8'h69, 0, "f69", 1'b0, 8'h00);
    expect_frame(8'h0A, 0, "f0A", 1'b0, 8'h00);
    check("b2b busy end", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Six consecutive writes into a depth-4 FIFO
    wr_en = 1'b1; wr_data = 8'h01;
    @(negedge clk);
    check("ovf empty after w1", 32'(empty), 32'd0);
    wr_data = 8'h02;
    @(negedge clk);
    check("ovf first pop tx", 32'(tx), 32'd0);
    wr_data = 8'h03;
    @(negedge clk);
    wr_data = 8'h04;
    @(negedge clk);
    check("ovf full after w4", 32'(full), 32'd0);
    wr_data = 8'h05;
    @(negedge clk);
    check("ovf full after w5", 32'(full), 32'd1);
    check("ovf flag before w6", 32'(ovf), 32'd0);
    wr_data = 8'h06;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf flag after w6", 32'(ovf), 32'd1);
    check("ovf still full", 32'(full), 32'd1);
    expect_frame(8'h01, 4, "q01", 1'b0, 8'h00);
    expect_frame(8'h02, 0, "q02", 1'b0, 8'h00);
    expect_frame(8'h03, 0, "q03", 1'b0, 8'h00);
    expect_frame(8'h04, 0, "q04", 1'b0, 8'h00);
    expect_frame(8'h05, 0, "q05", 1'b0, 8'h00);
    check("ovf busy end", 32'(busy), 32'd0);
    for (int i = 0; i < 120; i++) begin
      check("no sixth frame tx", 32'(tx), 32'd1);
      @(negedge clk);
    end
    check("ovf sticky", 32'(ovf), 32'd1);

    // Reset during a frame discards it and the queued byte
    write_byte(8'h55);
    write_byte(8'h77);
    repeat (35) @(negedge clk);
    check("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst tx", 32'(tx), 32'd1);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("post-rst idle tx", 32'(tx), 32'd1);
      @(negedge clk);
    end
    write_byte(8'h33);
    @(negedge clk);
    expect_frame(8'h33, 0, "f33", 1'b0, 8'h00);
    check("f33 busy end", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Write on the same edge as stop completion: one idle-high cycle then start
    write_byte(8'h00);
    @(negedge clk);
    expect_frame(8'h00, 0, "f00", 1'b1, 8'hFF);
    check("bnd idle tx", 32'(tx), 32'd1);
    check("bnd empty", 32'(empty), 32'd0);
    check("bnd busy", 32'(busy), 32'd1);
    @(negedge clk);
    expect_frame(8'hFF, 0, "fFF", 1'b0, 8'h00);
    check("fFF busy end", 32'(busy), 32'd0);
    check("fFF empty end", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
